ub_ctrl: RTL and testbench

UB_CTRL -- requirements
Module: ub_ctrl

---
 rtl/ub_pkg.sv | 40 ++++
 rtl/ub_rr_arb.sv | 47 ++++
 rtl/ub_ctrl.sv | 148 ++++++++++++++
 tb/tb_ub_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ub_pkg
//  Description : Shared constants, FSM state encoding and pointer helper for
//                the unified-buffer controller.
//  Revision    : 1.0  initial release
// ============================================================================
package ub_pkg;

    // Address width of every unified-buffer address and pointer
    localparam int unsigned ADDR_W   = 13;
    // Default buffer depth in words
    localparam int unsigned UB_DEPTH = 64;
    // Words moved per store or load (one 2x2 tile)
    localparam int unsigned BURST    = 4;

    // Requester indices into the arbiter request/grant vectors
    localparam int unsigned REQ_STORE = 0;
    localparam int unsigned REQ_LOAD  = 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STORE     = 2'd1,
        ST_LOAD      = 2'd2,
        ST_LOAD_WAIT = 2'd3
    } ub_state_e;

    // Folds a raw pointer into the buffer and aligns it down to a tile start
    function automatic logic [ADDR_W-1:0] align_ptr(
        input int unsigned val,
        input int unsigned depth,
        input int unsigned burst
    );
        int unsigned m;
        m = val % depth;
        return ADDR_W'(m - (m % burst));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ub_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ub_rr_arb
//  Description : Two-requester round-robin arbiter. On contention the
//                requester that was not granted last wins; after reset the
//                store requester (index 0) has priority.
//  Revision    : 1.0  initial release
// ============================================================================
module ub_rr_arb
    import ub_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // High when the load requester received the most recent grant
    logic last_load_q;

    // Pick a winner; contention is broken against the last winner
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o[REQ_STORE] = last_load_q;
                gnt_o[REQ_LOAD]  = ~last_load_q;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Remember which class won; reset state favours the store class
    always_ff @(posedge clk) begin
        if (reset) begin
            last_load_q <= 1'b1;
        end else if (gnt_o[REQ_STORE]) begin
            last_load_q <= 1'b0;
        end else if (gnt_o[REQ_LOAD]) begin
            last_load_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ub_ctrl
//  Description : Unified-buffer controller. Arbitrates accumulator tile
//                stores against activation tile loads, drives the buffer
//                address/strobes and maintains the store write pointer.
//                All outputs come straight from registers.
//  Revision    : 1.0  initial release
// ============================================================================
module ub_ctrl
    import ub_pkg::*;
#(
    parameter int unsigned UB_DEPTH = ub_pkg::UB_DEPTH,
    parameter int unsigned BURST    = ub_pkg::BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              store_acc1,
    input  logic              store_acc2,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              cfg_wr,
    input  logic [ADDR_W-1:0] cfg_ptr,
    output logic [ADDR_W-1:0] ub_addr,
    output logic              ub_store,
    output logic              ub_load_input,
    output logic              store_ack,
    output logic              load_ack,
    output logic              load_valid,
    output logic              load_err,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              busy
);

    ub_state_e         state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] ub_addr_q;
    logic              ub_store_q;
    logic              ub_load_q;
    logic              store_ack_q;
    logic              load_ack_q;
    logic              load_valid_q;
    logic              load_err_q;
    logic              busy_q;

    logic              store_req;
    logic              load_req_live;
    logic              load_in_range;
    logic              arb_en;
    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;

    // Request qualification: a load whose ack is on the wire this cycle has
    // already been answered, so it is not offered to the arbiter again.
    always_comb begin
        store_req     = store_acc1 & store_acc2;
        load_req_live = load_req & ~load_ack_q;
        load_in_range = (32'(load_addr) <= (UB_DEPTH - BURST));
        arb_en        = (state_q == ST_IDLE) & ~cfg_wr;
        arb_req       = 2'b00;
        arb_req[REQ_STORE] = store_req;
        arb_req[REQ_LOAD]  = load_req_live;
    end

    ub_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (arb_en),
        .req_i (arb_req),
        .gnt_o (arb_gnt)
    );

    // Controller FSM with registered strobes, pulses, address and pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            ub_addr_q    <= '0;
            ub_store_q   <= 1'b0;
            ub_load_q    <= 1'b0;
            store_ack_q  <= 1'b0;
            load_ack_q   <= 1'b0;
            load_valid_q <= 1'b0;
            load_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ub_store_q   <= 1'b0;
            ub_load_q    <= 1'b0;
            store_ack_q  <= 1'b0;
            load_ack_q   <= 1'b0;
            load_valid_q <= 1'b0;
            load_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_wr) begin
                        wr_ptr_q <= align_ptr(32'(cfg_ptr), UB_DEPTH, BURST);
                    end else if (arb_gnt[REQ_STORE]) begin
                        state_q     <= ST_STORE;
                        ub_addr_q   <= wr_ptr_q;
                        ub_store_q  <= 1'b1;
                        store_ack_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (arb_gnt[REQ_LOAD]) begin
                        load_ack_q <= 1'b1;
                        if (load_in_range) begin
                            state_q   <= ST_LOAD;
                            ub_addr_q <= load_addr;
                            ub_load_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            // Rejected tile: answer the requester and stay put
                            load_err_q <= 1'b1;
                        end
                    end
                end
                ST_STORE: begin
                    wr_ptr_q <= align_ptr(32'(wr_ptr_q) + BURST, UB_DEPTH, BURST);
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                end
                ST_LOAD: begin
                    load_valid_q <= 1'b1;
                    state_q      <= ST_LOAD_WAIT;
                end
                ST_LOAD_WAIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ub_addr       = ub_addr_q;
    assign ub_store      = ub_store_q;
    assign ub_load_input = ub_load_q;
    assign store_ack     = store_ack_q;
    assign load_ack      = load_ack_q;
    assign load_valid    = load_valid_q;
    assign load_err      = load_err_q;
    assign wr_ptr        = wr_ptr_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ub_ctrl
//  Description : Self-checking bench for ub_ctrl. A cycle schedule model
//                predicts every output each cycle; directed scenarios add
//                literal checks of latencies, addresses and buffer data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ub_ctrl;

    localparam int DEPTH = 64;
    localparam int BUR   = 4;

    logic        clk;
    logic        reset;
    logic        store_acc1, store_acc2, load_req, cfg_wr;
    logic [12:0] load_addr, cfg_ptr;
    logic [12:0] ub_addr, wr_ptr;
    logic        ub_store, ub_load_input, store_ack, load_ack;
    logic        load_valid, load_err, busy;

    int total = 0;
    int bad   = 0;

    ub_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .store_acc1    (store_acc1),
        .store_acc2    (store_acc2),
        .load_req      (load_req),
        .load_addr     (load_addr),
        .cfg_wr        (cfg_wr),
        .cfg_ptr       (cfg_ptr),
        .ub_addr       (ub_addr),
        .ub_store      (ub_store),
        .ub_load_input (ub_load_input),
        .store_ack     (store_ack),
        .load_ack      (load_ack),
        .load_valid    (load_valid),
        .load_err      (load_err),
        .wr_ptr        (wr_ptr),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- unified buffer model ----------------
    int mem [DEPTH];
    int rd  [BUR];
    int wdata = 100;

    always @(posedge clk) begin
        if (!reset) begin
            if (ub_store) begin
                for (int i = 0; i < BUR; i++) begin
                    mem[(int'(ub_addr) + i) % DEPTH] = wdata;
                    wdata++;
                end
            end
            if (ub_load_input) begin
                for (int i = 0; i < BUR; i++) rd[i] = mem[(int'(ub_addr) + i) % DEPTH];
            end
        end
    end

    // ---------------- behavioural schedule model ----------------
    typedef struct packed {
        logic        st;
        logic        ld;
        logic        sack;
        logic        lack;
        logic        lval;
        logic        lerr;
        logic        busy;
        logic [12:0] addr;
        logic [12:0] wr;
    } ov_t;

    ov_t cur;
    ov_t sched[$];
    int  m_wr;
    int  m_addr;
    bit  m_last_load;
    bit  started = 0;

    function automatic ov_t quiet(input int a, input int w);
        ov_t v;
        v = '0;
        v.addr = 13'(a);
        v.wr   = 13'(w);
        return v;
    endfunction

    always @(posedge clk) begin
        ov_t v;
        bit  idle, sreq, lreq, gs, gl;
        started = 1;
        if (reset) begin
            sched.delete();
            m_wr = 0;
            m_addr = 0;
            m_last_load = 1;
            cur = '0;
        end else begin
            idle = (sched.size() == 0) && !cur.busy;
            if (idle) begin
                if (cfg_wr) begin
                    m_wr = ((int'(cfg_ptr) % DEPTH) / BUR) * BUR;
                end else begin
                    sreq = store_acc1 && store_acc2;
                    lreq = load_req && !cur.lack;
                    gs = sreq && (!lreq || m_last_load);
                    gl = lreq && !gs;
                    if (gs) begin
                        v = quiet(m_wr, m_wr);
                        v.st = 1; v.sack = 1; v.busy = 1;
                        sched.push_back(v);
                        m_addr = m_wr;
                        m_wr = (m_wr + BUR) % DEPTH;
                        m_last_load = 0;
                    end else if (gl) begin
                        m_last_load = 1;
                        if (int'(load_addr) <= DEPTH - BUR) begin
                            m_addr = int'(load_addr);
                            v = quiet(m_addr, m_wr);
                            v.ld = 1; v.lack = 1; v.busy = 1;
                            sched.push_back(v);
                            v = quiet(m_addr, m_wr);
                            v.lval = 1; v.busy = 1;
                            sched.push_back(v);
                        end else begin
                            v = quiet(m_addr, m_wr);
                            v.lerr = 1; v.lack = 1;
                            sched.push_back(v);
                        end
                    end
                end
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = quiet(m_addr, m_wr);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        ov_t d;
        if (started) begin
            d = {ub_store, ub_load_input, store_ack, load_ack, load_valid, load_err,
                 busy, ub_addr, wr_ptr};
            total++;
            if (d !== cur) begin
                bad++;
                $display("FAIL cycle_model t=%0t actual st=%b ld=%b sack=%b lack=%b val=%b err=%b busy=%b addr=%0d wr=%0d required st=%b ld=%b sack=%b lack=%b val=%b err=%b busy=%b addr=%0d wr=%0d",
                         $time, d.st, d.ld, d.sack, d.lack, d.lval, d.lerr, d.busy, d.addr, d.wr,
                         cur.st, cur.ld, cur.sack, cur.lack, cur.lval, cur.lerr, cur.busy, cur.addr, cur.wr);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // which: 0 store_ack, 1 load_ack, 2 load_valid
    task automatic wait_for(input int which, input int bound, output int cnt);
        bit hit;
        hit = 0;
        cnt = 0;
        while (!hit && cnt < bound) begin
            @(negedge clk);
            cnt++;
            case (which)
                0: hit = store_ack;
                1: hit = load_ack;
                default: hit = load_valid;
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL wait%0d actual=no_pulse required=pulse_within_%0d", which, bound);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int cnt;
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;
        mem[30] = 11; mem[31] = 12; mem[32] = 21; mem[33] = 22;
        reset = 1; store_acc1 = 0; store_acc2 = 0; load_req = 0;
        load_addr = '0; cfg_wr = 0; cfg_ptr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr", int'(wr_ptr), 0);
        chk("rst_addr", int'(ub_addr), 0);
        reset = 0;
        @(negedge clk);

        // first store after reset lands at 0
        store_acc1 = 1; store_acc2 = 1;
        wait_for(0, 5, cnt);
        chk("st_lat", cnt, 1);
        chk("st_addr", int'(ub_addr), 0);
        chk("st_strobe", int'(ub_store), 1);
        store_acc1 = 0; store_acc2 = 0;
        @(negedge clk);
        chk("st_wr", int'(wr_ptr), 4);
        chk("st_idle", int'(busy), 0);

        // load tile at 30
        load_req = 1; load_addr = 13'd30;
        wait_for(1, 5, cnt);
        chk("ld_ack_lat", cnt, 1);
        chk("ld_addr", int'(ub_addr), 30);
        chk("ld_strobe", int'(ub_load_input), 1);
        load_req = 0;
        wait_for(2, 3, cnt);
        chk("ld_val_lat", cnt, 1);
        chk("ld_d0", rd[0], 11);
        chk("ld_d1", rd[1], 12);
        chk("ld_d2", rd[2], 21);
        chk("ld_d3", rd[3], 22);

        // two contested rounds: store then load
        store_acc1 = 1; store_acc2 = 1; load_req = 1; load_addr = 13'd8;
        wait_for(0, 5, cnt);
        chk("rr1_no_lack", int'(load_ack), 0);
        chk("rr1_addr", int'(ub_addr), 4);
        store_acc1 = 0; store_acc2 = 0;
        @(negedge clk);
        store_acc1 = 1; store_acc2 = 1;
        wait_for(1, 3, cnt);
        chk("rr2_lat", cnt, 1);
        chk("rr2_no_sack", int'(store_ack), 0);
        chk("rr2_addr", int'(ub_addr), 8);
        load_req = 0;
        wait_for(0, 6, cnt);
        chk("rr3_addr", int'(ub_addr), 8);
        store_acc1 = 0; store_acc2 = 0;
        @(negedge clk);
        chk("rr3_wr", int'(wr_ptr), 12);

        // cfg to 60 blocks the pending store for one cycle, then wraps
        cfg_wr = 1; cfg_ptr = 13'd60; store_acc1 = 1; store_acc2 = 1;
        @(negedge clk);
        cfg_wr = 0;
        chk("cfg_wr60", int'(wr_ptr), 60);
        chk("cfg_blocks", int'(store_ack), 0);
        wait_for(0, 3, cnt);
        chk("cfg_st_lat", cnt, 1);
        chk("wrap_addr", int'(ub_addr), 60);
        store_acc1 = 0; store_acc2 = 0;
        @(negedge clk);
        chk("wrap_wr", int'(wr_ptr), 0);

        // unaligned, out-of-range cfg pointer: 4102 mod 64 = 6 -> 4
        cfg_wr = 1; cfg_ptr = 13'd4102;
        @(negedge clk);
        cfg_wr = 0;
        chk("cfg_align", int'(wr_ptr), 4);

        // cfg while storing is ignored
        store_acc1 = 1; store_acc2 = 1;
        wait_for(0, 3, cnt);
        store_acc1 = 0; store_acc2 = 0;
        cfg_wr = 1; cfg_ptr = 13'd40;
        @(negedge clk);
        cfg_wr = 0;
        chk("cfg_ignored", int'(wr_ptr), 8);

        // out-of-range load
        load_req = 1; load_addr = 13'd61;
        wait_for(1, 3, cnt);
        chk("err_pulse", int'(load_err), 1);
        chk("err_no_strobe", int'(ub_load_input), 0);
        chk("err_busy", int'(busy), 0);
        load_req = 0;
        @(negedge clk);
        chk("err_clear", int'(load_err), 0);

        // highest legal tile start
        load_req = 1; load_addr = 13'd60;
        wait_for(1, 3, cnt);
        chk("edge_strobe", int'(ub_load_input), 1);
        chk("edge_addr", int'(ub_addr), 60);
        load_req = 0;
        wait_for(2, 3, cnt);
        @(negedge clk);

        // reset while load is in flight suppresses load_valid
        load_req = 1; load_addr = 13'd4;
        wait_for(1, 3, cnt);
        load_req = 0;
        reset = 1;
        @(negedge clk);
        chk("abort_val", int'(load_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_wr", int'(wr_ptr), 0);
        reset = 0;
        @(negedge clk);

        // after reset the store class wins contention again
        store_acc1 = 1; store_acc2 = 1; load_req = 1; load_addr = 13'd12;
        wait_for(0, 4, cnt);
        chk("post_rst_store", int'(load_ack), 0);
        chk("post_rst_addr", int'(ub_addr), 0);
        store_acc1 = 0; store_acc2 = 0;
        wait_for(1, 4, cnt);
        load_req = 0;
        wait_for(2, 3, cnt);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
